seg7_scan_out: RTL and testbench

Multiplexed six-digit 7-segment display driver for the CLOCK24 board: the output-side counterpart of the debounced button input path. It takes six BCD digits (HH:MM:SS), a per-digit blink mask and decimal-point mask. It time-multiplexes them onto shared active-low segment lines and active-low digit enables. Anti-ghosting guard blanking is applied at every digit change.

---
 rtl/seg7_scan_out_if.sv | 38 +++
 rtl/seg7_scan_out.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_out.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_out_if
//  Description : Bundles the display data inputs (DIN, BLINK, DP) and the
//                multiplexed pin outputs (nDIGIT, nSEG) of seg7_scan_out.
//                master = display data source / pin observer
//                slave  = the scan driver itself
//  Signals     : DIN[23:0]   six BCD digits, digit i = DIN[4i+3:4i]
//                BLINK[5:0]  per-digit blink enable
//                DP[5:0]     per-digit decimal point, 1 = lit
//                nDIGIT[5:0] digit enables, active low
//                nSEG[7:0]   segments, active low, [7]=dp, [6:0]=g..a
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_out_if;
    logic [23:0] DIN;
    logic [5:0]  BLINK;
    logic [5:0]  DP;
    logic [5:0]  nDIGIT;
    logic [7:0]  nSEG;

    modport master (
        output DIN,
        output BLINK,
        output DP,
        input  nDIGIT,
        input  nSEG
    );

    modport slave (
        input  DIN,
        input  BLINK,
        input  DP,
        output nDIGIT,
        output nSEG
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_out.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_out
//  Description : Six-digit multiplexed 7-segment driver for the CLOCK24
//                board. Each digit owns one slot of SCAN_DIV cycles; the
//                first GUARD cycles of every slot are blanked to suppress
//                ghosting. Digits with BLINK set are hidden for alternating
//                runs of BLINK_SLOTS slots.
//  Ports       : CLK      system clock
//                RST      synchronous active-high reset
//                bus      seg7_scan_out_if.slave
//                         (DIN, BLINK, DP in; nDIGIT, nSEG out)
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_out #(
    parameter int SCAN_DIV    = 50000,
    parameter int GUARD       = 500,
    parameter int BLINK_SLOTS = 250
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    seg7_scan_out_if.slave       bus
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    localparam logic [CW-1:0] C_CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_GUARD     = CW'(GUARD);
    localparam logic [BW-1:0] C_BCNT_LAST = BW'(BLINK_SLOTS - 1);
    localparam logic [2:0]    C_IDX_LAST  = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    idx_q,     idx_d;
    logic [BW-1:0] bcnt_q,    bcnt_d;
    logic          phase_q,   phase_d;
    logic [3:0]    cap_val_q, cap_val_d;
    logic          cap_bl_q,  cap_bl_d;
    logic          cap_dp_q,  cap_dp_d;
    logic [5:0]    ndigit_q,  ndigit_d;
    logic [7:0]    nseg_q,    nseg_d;

    logic          w_slot_tick;
    logic          w_blank;
    logic [3:0]    w_sel_val;
    logic          w_sel_bl;
    logic          w_sel_dp;

    // Active-low segment pattern g..a for one BCD code; non-BCD codes
    // leave every segment dark.
    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Digit selection from the live inputs (only used at cnt == 0)
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_val = bus.DIN[3:0];
        w_sel_bl  = bus.BLINK[0];
        w_sel_dp  = bus.DP[0];
        case (idx_q)
            3'd1: begin
                w_sel_val = bus.DIN[7:4];
                w_sel_bl  = bus.BLINK[1];
                w_sel_dp  = bus.DP[1];
            end
            3'd2: begin
                w_sel_val = bus.DIN[11:8];
                w_sel_bl  = bus.BLINK[2];
                w_sel_dp  = bus.DP[2];
            end
            3'd3: begin
                w_sel_val = bus.DIN[15:12];
                w_sel_bl  = bus.BLINK[3];
                w_sel_dp  = bus.DP[3];
            end
            3'd4: begin
                w_sel_val = bus.DIN[19:16];
                w_sel_bl  = bus.BLINK[4];
                w_sel_dp  = bus.DP[4];
            end
            3'd5: begin
                w_sel_val = bus.DIN[23:20];
                w_sel_bl  = bus.BLINK[5];
                w_sel_dp  = bus.DP[5];
            end
            default: begin
                w_sel_val = bus.DIN[3:0];
                w_sel_bl  = bus.BLINK[0];
                w_sel_dp  = bus.DP[0];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_tick = (cnt_q == C_CNT_LAST);

        cnt_d     = w_slot_tick ? '0 : cnt_q + CW'(1);

        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
        if (w_slot_tick) begin
            idx_d = (idx_q == C_IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            // Phase only moves on a slot boundary, so blink never cuts a
            // slot in half.
            if (bcnt_q == C_BCNT_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
            end
        end

        // Snapshot the digit at slot start so mid-slot input changes
        // cannot tear the displayed value.
        cap_val_d = cap_val_q;
        cap_bl_d  = cap_bl_q;
        cap_dp_d  = cap_dp_q;
        if (cnt_q == '0) begin
            cap_val_d = w_sel_val;
            cap_bl_d  = w_sel_bl;
            cap_dp_d  = w_sel_dp;
        end

        // The capture lands during guard time, so the stale snapshot seen
        // at cnt == 0 is always hidden by the guard blank.
        w_blank = (cnt_q < C_GUARD) || (cap_bl_q && !phase_q);

        if (w_blank) begin
            ndigit_d = 6'h3F;
            nseg_d   = 8'hFF;
        end else begin
            ndigit_d = ~(6'b000001 << idx_q);
            nseg_d   = {~cap_dp_q, f_decode(cap_val_q)};
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            bcnt_q    <= '0;
            phase_q   <= 1'b1;
            cap_val_q <= 4'd0;
            cap_bl_q  <= 1'b0;
            cap_dp_q  <= 1'b0;
            ndigit_q  <= 6'h3F;
            nseg_q    <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            cap_val_q <= cap_val_d;
            cap_bl_q  <= cap_bl_d;
            cap_dp_q  <= cap_dp_d;
            ndigit_q  <= ndigit_d;
            nseg_q    <= nseg_d;
        end
    end

    assign bus.nDIGIT = ndigit_q;
    assign bus.nSEG   = nseg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_out
//  Description : Self-checking bench for seg7_scan_out with a time-based
//                reference model (cycle count since reset -> slot, digit,
//                blink phase) and randomized display data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_out;
    localparam int D = 8;   // SCAN_DIV
    localparam int G = 2;   // GUARD
    localparam int B = 3;   // BLINK_SLOTS

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_out_if bus_if();

    seg7_scan_out #(
        .SCAN_DIV    (D),
        .GUARD       (G),
        .BLINK_SLOTS (B)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: t = cycles since the reset state appeared on the pins.
    int          t = 0;
    logic [3:0]  m_val = 4'd0;
    bit          m_bl  = 1'b0;
    bit          m_dp  = 1'b0;
    logic [6:0]  seg_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    endtask

    // Compare the pins of cycle t against the model.
    task automatic check_pins;
        logic [5:0] e_dig;
        logic [7:0] e_seg;
        int s, cnt, slot, idx, zeros;
        bit visible_phase;
        e_dig = 6'h3F;
        e_seg = 8'hFF;
        if (t > 0) begin
            s    = t - 1;              // state that produced this cycle's pins
            cnt  = s % D;
            slot = s / D;
            idx  = slot % 6;
            visible_phase = (((slot / B) % 2) == 0);
            if (!(cnt < G) && !(m_bl && !visible_phase)) begin
                e_dig = ~(6'b000001 << idx);
                e_seg = {~m_dp, seg_tab[m_val]};
            end
        end
        chk("nDIGIT", {26'd0, bus_if.nDIGIT}, {26'd0, e_dig});
        chk("nSEG",   {24'd0, bus_if.nSEG},   {24'd0, e_seg});
        zeros = 0;
        for (int k = 0; k < 6; k++) if (bus_if.nDIGIT[k] == 1'b0) zeros++;
        chk("onehot", (zeros <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Advance one clock with the inputs currently applied.
    task automatic tick(input bit do_rst);
        logic [23:0] din_v;
        int idx;
        rst = do_rst;
        if ((t % D) == 0) begin
            din_v = bus_if.DIN;
            idx   = (t / D) % 6;
            m_val = din_v[4*idx +: 4];
            m_bl  = bus_if.BLINK[idx];
            m_dp  = bus_if.DP[idx];
        end
        @(posedge clk);
        #1;
        if (do_rst) t = 0;
        else        t++;
        check_pins();
    endtask

    initial begin
        bit found;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

        bus_if.DIN   = 24'h123456;
        bus_if.BLINK = 6'd0;
        bus_if.DP    = 6'd0;
        #1;

        // Reset, first slot, full scan and a mid-slot digit change.
        tick(1'b1);
        tick(1'b1);
        for (int i = 0; i < 110; i++) begin
            if (t == 4) bus_if.DIN[3:0] = 4'd1;
            tick(1'b0);
        end

        // Decode edges: digit 8 with dp, then an invalid code without dp.
        bus_if.DIN = 24'h000008;
        bus_if.DP  = 6'b000001;
        tick(1'b1);
        for (int i = 0; i < 60; i++) tick(1'b0);
        bus_if.DIN = 24'h00000B;
        bus_if.DP  = 6'b000000;
        tick(1'b1);
        for (int i = 0; i < 60; i++) tick(1'b0);

        // Blink on digits whose slots fall in hidden phases and in visible ones.
        bus_if.DIN   = 24'h987654;
        bus_if.BLINK = 6'b001001;
        bus_if.DP    = 6'b101010;
        tick(1'b1);
        for (int i = 0; i < 150; i++) tick(1'b0);

        // Reset at idx=3, cnt=5 while the blink phase is hidden.
        bus_if.BLINK = 6'b001000;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if ((((t / D) % 6) == 3) && ((t % D) == 5) && ((((t / D) / B) % 2) == 1))
                found = 1'b1;
            else
                tick(1'b0);
        end
        chk("rst_point_reached", {31'd0, found}, 32'd1);
        tick(1'b1);
        for (int i = 0; i < 60; i++) tick(1'b0);

        // Randomized inputs with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus_if.DIN   = 24'($urandom);
                bus_if.BLINK = 6'($urandom);
                bus_if.DP    = 6'($urandom);
            end
            tick($urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
